exec_datapath: RTL and testbench

- Parametrised multicycle execute stage for the ARM-style core: latches operands, runs the barrel shift, then the ALU, and holds result F and the NZCV flags.
- Generalises the fixed 32-bit A/B/C/F execute path to DATA_W bits.
- Adds a valid/ready issue and completion handshake, so the controller can stall on results.
- Sits between register read and register/PC writeback.

---
 rtl/exec_datapath.sv | 208 ++++++++++++++++++++
 tb/tb_exec_datapath.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/exec_datapath.sv
// Multicycle execute stage: operand latch, barrel shift, ALU with NZCV, and valid/ready handshakes.
// Optional iterative multiplier is enabled by defining EXEC_DATAPATH_MUL_EN.
module exec_datapath #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [SHAMT_W-1:0] op_shamt,
  input  logic [2:0]         shift_op,
  input  logic [3:0]         alu_op,
  input  logic               s_flag,
  input  logic               mul_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               result_we,
  output logic [3:0]         nzcv,
  output logic               busy
);

  localparam int LOG_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SHIFT, EXEC, MUL, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   opA_q, opB_q, shData_q, f_q;
  logic [SHAMT_W-1:0]  amt_q;
  logic [2:0]          shiftOp_q;
  logic [3:0]          aluOp_q, nzcv_q;
  logic                sFlag_q, mulReq_q, shCarry_q, resultWe_q, outValid_q;

  logic [DATA_W-1:0]   shData_d, aluF_d, rorData, addX, addY;
  logic                shCarry_d, addCin, isArith, aluC, aluV;
  logic [3:0]          aluNzcv_d;
  logic [31:0]         amtExt;
  logic [DATA_W:0]     lslWide, lsrWide, asrWide, addSum;

  assign amtExt  = 32'(amt_q);
  assign lslWide = {1'b0, opB_q} << amtExt;
  assign lsrWide = {opB_q, 1'b0} >> amtExt;
  assign asrWide = $unsigned($signed({opB_q, 1'b0}) >>> amtExt);
  assign rorData = DATA_W'({opB_q, opB_q} >> amtExt[LOG_W-1:0]);

  // Extra guard bit on each side of the shift captures the last bit shifted out as the carry.
  always_comb begin
    shData_d  = opB_q;
    shCarry_d = nzcv_q[1];
    if (shiftOp_q == 3'b100) begin
      shData_d  = {nzcv_q[1], opB_q[DATA_W-1:1]};
      shCarry_d = opB_q[0];
    end else if (amtExt != 32'd0) begin
      case (shiftOp_q)
        3'b000: begin
          shData_d  = (amtExt <= 32'(DATA_W)) ? lslWide[DATA_W-1:0] : '0;
          shCarry_d = (amtExt <= 32'(DATA_W)) ? lslWide[DATA_W] : 1'b0;
        end
        3'b001: begin
          shData_d  = (amtExt <= 32'(DATA_W)) ? lsrWide[DATA_W:1] : '0;
          shCarry_d = (amtExt <= 32'(DATA_W)) ? lsrWide[0] : 1'b0;
        end
        3'b010: begin
          shData_d  = (amtExt < 32'(DATA_W)) ? asrWide[DATA_W:1] : {DATA_W{opB_q[DATA_W-1]}};
          shCarry_d = (amtExt < 32'(DATA_W)) ? asrWide[0] : opB_q[DATA_W-1];
        end
        3'b011: begin
          shData_d  = rorData;
          shCarry_d = rorData[DATA_W-1];
        end
        default: ;
      endcase
    end
  end

  // Subtracts are add-with-inverted-operand so C comes out as NOT borrow.
  always_comb begin
    addX    = opA_q;
    addY    = shData_q;
    addCin  = 1'b0;
    isArith = 1'b1;
    case (aluOp_q)
      4'b0010, 4'b1010: begin addY = ~shData_q; addCin = 1'b1; end
      4'b0011:          begin addX = shData_q; addY = ~opA_q; addCin = 1'b1; end
      4'b0100, 4'b1011: ;
      4'b0101:          addCin = nzcv_q[1];
      4'b0110:          begin addY = ~shData_q; addCin = nzcv_q[1]; end
      4'b0111:          begin addX = shData_q; addY = ~opA_q; addCin = nzcv_q[1]; end
      default:          isArith = 1'b0;
    endcase
  end

  assign addSum = {1'b0, addX} + {1'b0, addY} + {{DATA_W{1'b0}}, addCin};

  always_comb begin
    case (aluOp_q)
      4'b0000, 4'b1000: aluF_d = opA_q & shData_q;
      4'b0001, 4'b1001: aluF_d = opA_q ^ shData_q;
      4'b1100:          aluF_d = opA_q | shData_q;
      4'b1101:          aluF_d = shData_q;
      4'b1110:          aluF_d = opA_q & ~shData_q;
      4'b1111:          aluF_d = ~shData_q;
      default:          aluF_d = addSum[DATA_W-1:0];
    endcase
    aluC = isArith ? addSum[DATA_W] : shCarry_q;
    aluV = isArith ? ((addX[DATA_W-1] == addY[DATA_W-1]) && (aluF_d[DATA_W-1] != addX[DATA_W-1]))
                   : nzcv_q[0];
    aluNzcv_d = {aluF_d[DATA_W-1], (aluF_d == '0), aluC, aluV};
  end

`ifdef EXEC_DATAPATH_MUL_EN
  logic [LOG_W-1:0]  mulCnt_q;
  logic [DATA_W-1:0] mulAcc_d;
  assign mulAcc_d = f_q + (shData_q[0] ? opA_q : '0);
`else
  logic unusedMulReq;
  assign unusedMulReq = mulReq_q;
`endif

  // In MUL, opA_q is the shifting multiplicand, shData_q the multiplier and f_q the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      amt_q      <= '0;
      shiftOp_q  <= '0;
      aluOp_q    <= '0;
      sFlag_q    <= 1'b0;
      mulReq_q   <= 1'b0;
      shData_q   <= '0;
      shCarry_q  <= 1'b0;
      f_q        <= '0;
      nzcv_q     <= '0;
      resultWe_q <= 1'b0;
      outValid_q <= 1'b0;
`ifdef EXEC_DATAPATH_MUL_EN
      mulCnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opA_q     <= op_a;
            opB_q     <= op_b;
            amt_q     <= op_shamt;
            shiftOp_q <= shift_op;
            aluOp_q   <= alu_op;
            sFlag_q   <= s_flag;
            mulReq_q  <= mul_req;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shData_q  <= shData_d;
          shCarry_q <= shCarry_d;
`ifdef EXEC_DATAPATH_MUL_EN
          if (mulReq_q) begin
            f_q      <= '0;
            mulCnt_q <= '0;
            state_q  <= MUL;
          end else
`endif
          state_q <= EXEC;
        end
        EXEC: begin
          f_q        <= aluF_d;
          resultWe_q <= (aluOp_q[3:2] != 2'b10);
          if (sFlag_q) nzcv_q <= aluNzcv_d;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
`ifdef EXEC_DATAPATH_MUL_EN
        MUL: begin
          f_q      <= mulAcc_d;
          opA_q    <= opA_q << 1;
          shData_q <= shData_q >> 1;
          mulCnt_q <= mulCnt_q + 1'b1;
          if (mulCnt_q == LOG_W'(DATA_W - 1)) begin
            resultWe_q <= 1'b1;
            outValid_q <= 1'b1;
            if (sFlag_q) nzcv_q[3:2] <= {mulAcc_d[DATA_W-1], (mulAcc_d == '0)};
            state_q    <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign result    = f_q;
  assign result_we = resultWe_q;
  assign nzcv      = nzcv_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Directed testbench for exec_datapath: shifter/ALU/flag vectors, backpressure and mid-operation reset.
// Expected multiply results switch on EXEC_DATAPATH_MUL_EN.
module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, s_flag, mul_req, out_valid, out_ready, result_we, busy;
  logic [31:0] op_a, op_b, result;
  logic [7:0]  op_shamt;
  logic [2:0]  shift_op;
  logic [3:0]  alu_op, nzcv;
  int          checks = 0;
  int          errors = 0;

  exec_datapath #(.DATA_W(32), .SHAMT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_shamt(op_shamt), .shift_op(shift_op),
    .alu_op(alu_op), .s_flag(s_flag), .mul_req(mul_req),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_we(result_we), .nzcv(nzcv), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, then scramble the operand inputs to prove they were latched.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [7:0] sh,
                               input logic [2:0] sop, input logic [3:0] aop, input logic s,
                               input logic m);
    checkOutput("issue_in_ready", 64'(in_ready), 64'd1);
    op_a = a; op_b = b; op_shamt = sh; shift_op = sop; alu_op = aop; s_flag = s; mul_req = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; op_shamt = 8'($urandom);
    shift_op = 3'($urandom); alu_op = 4'($urandom); s_flag = ~s; mul_req = ~m;
  endtask

  task automatic waitResult(input string tag, input int expLat);
    int lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(expLat));
  endtask

  task automatic finishTxn(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  task automatic runTxn(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [7:0] sh, input logic [2:0] sop, input logic [3:0] aop,
                        input logic s, input logic [31:0] expRes, input logic [3:0] expNzcv,
                        input logic expWe);
    applyStimulus(a, b, sh, sop, aop, s, 1'b0);
    waitResult(tag, 3);
    checkOutput({tag, "_result"}, 64'(result), 64'(expRes));
    checkOutput({tag, "_nzcv"}, 64'(nzcv), 64'(expNzcv));
    checkOutput({tag, "_we"}, 64'(result_we), 64'(expWe));
    finishTxn(tag);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic checkIdleCleared(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_nzcv"}, 64'(nzcv), 64'd0);
    checkOutput({tag, "_result"}, 64'(result), 64'd0);
    checkOutput({tag, "_we"}, 64'(result_we), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; op_shamt = '0;
    shift_op = '0; alu_op = '0; s_flag = 1'b0; mul_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkIdleCleared("reset");

    runTxn("add_s", 32'hFFFF_FFFF, 32'h1, 8'd0, 3'b000, 4'b0100, 1'b1, 32'h0, 4'b0110, 1'b1);
    runTxn("sub_s", 32'h8000_0000, 32'h1, 8'd0, 3'b000, 4'b0010, 1'b1, 32'h7FFF_FFFF, 4'b0011, 1'b1);

    pulseReset();
    checkOutput("reset2_nzcv", 64'(nzcv), 64'd0);
    runTxn("mov_lsr1", 32'h0, 32'h8000_0001, 8'd1, 3'b001, 4'b1101, 1'b1, 32'h4000_0000, 4'b0010, 1'b1);
    runTxn("mov_ror32", 32'h0, 32'h8000_0000, 8'd32, 3'b011, 4'b1101, 1'b1, 32'h8000_0000, 4'b1010, 1'b1);
    runTxn("mov_ror40", 32'h0, 32'h8000_0000, 8'd40, 3'b011, 4'b1101, 1'b1, 32'h0080_0000, 4'b0000, 1'b1);
    runTxn("mov_lsl32", 32'h0, 32'h1, 8'd32, 3'b000, 4'b1101, 1'b1, 32'h0, 4'b0110, 1'b1);
    runTxn("mov_lsl33", 32'h0, 32'h1, 8'd33, 3'b000, 4'b1101, 1'b1, 32'h0, 4'b0100, 1'b1);
    runTxn("mov_asr40", 32'h0, 32'h8000_0000, 8'd40, 3'b010, 4'b1101, 1'b1, 32'hFFFF_FFFF, 4'b1010, 1'b1);
    runTxn("adc_cin", 32'h1, 32'h2, 8'd0, 3'b000, 4'b0101, 1'b1, 32'h4, 4'b0000, 1'b1);
    runTxn("mov_rrx", 32'h0, 32'h3, 8'd5, 3'b100, 4'b1101, 1'b1, 32'h1, 4'b0010, 1'b1);
    runTxn("eor_nos", 32'hF0, 32'h0F, 8'd0, 3'b000, 4'b0001, 1'b0, 32'hFF, 4'b0010, 1'b1);

    // Compare under backpressure; a pending issue must wait past the handshake cycle.
    applyStimulus(32'd5, 32'd5, 8'd0, 3'b000, 4'b1010, 1'b1, 1'b0);
    waitResult("cmp", 3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("cmp_hold_valid", 64'(out_valid), 64'd1);
      checkOutput("cmp_hold_result", 64'(result), 64'd0);
      checkOutput("cmp_hold_nzcv", 64'(nzcv), 64'b0110);
      checkOutput("cmp_hold_we", 64'(result_we), 64'd0);
      checkOutput("cmp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    checkOutput("cmp_release_in_ready", 64'(in_ready), 64'd1);
    checkOutput("cmp_release_busy", 64'(busy), 64'd0);

    applyStimulus(32'd3, 32'd4, 8'd0, 3'b000, 4'b0100, 1'b1, 1'b0);
    checkOutput("rst_shift_busy_before", 64'(busy), 64'd1);
    pulseReset();
    checkIdleCleared("rst_shift");
    repeat (4) @(posedge clk);
    #1 checkOutput("rst_shift_no_valid", 64'(out_valid), 64'd0);

    applyStimulus(32'd7, 32'd6, 8'd0, 3'b000, 4'b0100, 1'b1, 1'b1);
`ifdef EXEC_DATAPATH_MUL_EN
    waitResult("mul", 34);
    checkOutput("mul_result", 64'(result), 64'd42);
`else
    waitResult("mul", 3);
    checkOutput("mul_result", 64'(result), 64'd13);
`endif
    checkOutput("mul_nzcv", 64'(nzcv), 64'b0000);
    checkOutput("mul_we", 64'(result_we), 64'd1);
    finishTxn("mul");

    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd0, 3'b000, 4'b0100, 1'b1, 1'b0);
    waitResult("rst_done", 3);
    checkOutput("rst_done_result_before", 64'(result), 64'hFFFF_FFFE);
    checkOutput("rst_done_nzcv_before", 64'(nzcv), 64'b1010);
    pulseReset();
    checkIdleCleared("rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
